// File: rtl/vga_capture_if.sv
// Pin bundle between a VGA source and the capture block.
// The source drives sync and colour; the capture block drives the frame-buffer write port and status.
interface vga_capture_if;
    logic        h_sync;
    logic        v_sync;
    logic [3:0]  Red;
    logic [3:0]  Green;
    logic [3:0]  Blue;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [15:0] wr_data;
    logic        locked;
    logic        frame_done;
    logic        sync_err;

    modport master (
        output h_sync, v_sync, Red, Green, Blue,
        input  wr_en, wr_addr, wr_data, locked, frame_done, sync_err
    );

    modport slave (
        input  h_sync, v_sync, Red, Green, Blue,
        output wr_en, wr_addr, wr_data, locked, frame_done, sync_err
    );
endinterface

// File: rtl/vga_capture.sv
// VGA receiver: recovers raster position from sync falling edges, verifies one clean frame,
// then streams every visible pixel into a frame buffer write port.
module vga_capture #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT       = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 35,
    parameter int V_ACT       = 480
) (
    input  logic          clk,
    input  logic          rst,
    vga_capture_if.slave  bus
);
    localparam logic [1:0]  ST_SEARCH = 2'd0;
    localparam logic [1:0]  ST_ALIGN  = 2'd1;
    localparam logic [1:0]  ST_LOCKED = 2'd2;
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS_LO  = 10'(H_ACT_START);
    localparam logic [9:0]  H_VIS_HI  = 10'(H_ACT_START + H_ACT - 1);
    localparam logic [9:0]  V_VIS_LO  = 10'(V_ACT_START);
    localparam logic [9:0]  V_VIS_HI  = 10'(V_ACT_START + V_ACT - 1);
    localparam logic [18:0] ADDR_LAST = 19'(H_ACT * V_ACT - 1);

    // The receiver only needs the sync edges; the pulse width just has to clear the active window.
    if (H_SYNC >= H_ACT_START || H_ACT_START + H_ACT > H_TOTAL) begin : g_cfg_check
        $error("vga_capture: horizontal timing parameters are inconsistent");
    end

    logic        r_s_h, r_s_v, r_d_h, r_d_v;
    logic [11:0] r_s_rgb;
    logic [9:0]  r_h_pos, r_v_pos;
    logic [1:0]  r_state;
    logic        r_wr_en, r_frame_done, r_sync_err;
    logic [18:0] r_wr_addr;
    logic [15:0] r_wr_data;

    logic        w_h_fall, w_v_fall, w_viol, w_vis, w_write;
    logic [9:0]  w_h_pos, w_v_pos;
    logic [18:0] w_row, w_col, w_addr;
    logic [1:0]  w_state_next;

    assign w_h_fall = r_d_h & ~r_s_h;
    assign w_v_fall = r_d_v & ~r_s_v;

    // Position of the sample currently in the S stage; r_h_pos/r_v_pos hold the previous sample's.
    assign w_h_pos = w_h_fall ? 10'd0 : r_h_pos + 10'd1;
    assign w_v_pos = !w_h_fall ? r_v_pos : (w_v_fall ? 10'd0 : r_v_pos + 10'd1);

    assign w_viol = (w_h_fall && r_h_pos != H_LAST)
                  || (!w_h_fall && r_h_pos == H_LAST)
                  || (w_v_fall && (!w_h_fall || r_v_pos != V_LAST))
                  || (w_h_fall && !w_v_fall && r_v_pos == V_LAST);

    assign w_vis   = (w_h_pos >= H_VIS_LO) && (w_h_pos <= H_VIS_HI)
                  && (w_v_pos >= V_VIS_LO) && (w_v_pos <= V_VIS_HI);
    assign w_row   = 19'(w_v_pos - V_VIS_LO);
    assign w_col   = 19'(w_h_pos - H_VIS_LO);
    assign w_addr  = w_row * 19'(H_ACT) + w_col;
    assign w_write = (r_state == ST_LOCKED) && w_vis && !w_viol;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SEARCH: if (w_h_fall && w_v_fall) w_state_next = ST_ALIGN;
            ST_ALIGN: begin
                if (w_viol)                     w_state_next = ST_SEARCH;
                else if (w_h_fall && w_v_fall)  w_state_next = ST_LOCKED;
            end
            ST_LOCKED: if (w_viol) w_state_next = ST_SEARCH;
            default:   w_state_next = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_h        <= 1'b0;
            r_s_v        <= 1'b0;
            r_d_h        <= 1'b0;
            r_d_v        <= 1'b0;
            r_s_rgb      <= 12'h000;
            r_h_pos      <= 10'd0;
            r_v_pos      <= 10'd0;
            r_state      <= ST_SEARCH;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 19'd0;
            r_wr_data    <= 16'h0000;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_s_h        <= bus.h_sync;
            r_s_v        <= bus.v_sync;
            r_s_rgb      <= {bus.Red, bus.Green, bus.Blue};
            r_d_h        <= r_s_h;
            r_d_v        <= r_s_v;
            r_h_pos      <= w_h_pos;
            r_v_pos      <= w_v_pos;
            r_state      <= w_state_next;
            r_wr_en      <= w_write;
            r_frame_done <= w_write && (w_addr == ADDR_LAST);
            r_sync_err   <= w_viol && (r_state != ST_SEARCH);
            if (w_write) begin
                r_wr_addr <= w_addr;
                r_wr_data <= {4'h0, r_s_rgb};
            end
        end
    end

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.frame_done = r_frame_done;
    assign bus.sync_err   = r_sync_err;
    assign bus.locked     = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a reduced raster: frame-level lock model feeds a
// write scoreboard; a monitor pops and compares every write the DUT issues.
module tb_vga_capture;
    localparam int HT   = 40;
    localparam int HSW  = 4;
    localparam int HAS  = 8;
    localparam int HA   = 24;
    localparam int VT   = 20;
    localparam int VAS  = 4;
    localparam int VA   = 12;
    localparam int LAST = HA * VA - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vga_capture_if bus();

    vga_capture #(
        .H_TOTAL(HT), .H_SYNC(HSW), .H_ACT_START(HAS), .H_ACT(HA),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT(VA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0, n_fail = 0;
    int   n_err_seen = 0, n_err_exp = 0;
    int   n_wr_seen = 0, n_wr_exp = 0;
    int   n_fd_seen = 0, n_fd_exp = 0;
    int   frame_no = 0;
    bit   m_have = 1'b0;    // a frame start has been seen since the last fault/reset
    bit   m_locked = 1'b0;
    bit   chk_rst = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"},      int'(bus.wr_en), 0);
        check({tag, "_wr_addr"},    int'(bus.wr_addr), 0);
        check({tag, "_wr_data"},    int'(bus.wr_data), 0);
        check({tag, "_locked"},     int'(bus.locked), 0);
        check({tag, "_frame_done"}, int'(bus.frame_done), 0);
        check({tag, "_sync_err"},   int'(bus.sync_err), 0);
    endtask

    // Monitor: every write must match the oldest expected pixel, two cycles after it was driven.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            n_wr_seen++;
            if (bus.frame_done) n_fd_seen++;
            if (q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check("wr_addr", int'(bus.wr_addr), mon_e.addr);
                check("wr_data", int'(bus.wr_data), mon_e.data);
                check("frame_done", int'(bus.frame_done), int'(mon_e.addr == LAST));
                check("latency", cyc - mon_e.cyc, 2);
            end
        end else if (bus.frame_done) begin
            check("stray_frame_done", 1, 0);
        end
        if (bus.sync_err) begin
            n_err_seen++;
            check("locked_at_sync_err", int'(bus.locked), 0);
        end
    end

    function automatic int colour(input int mode, input int x, input int y, input bit vis);
        case (mode)
            0:       return (x + y) % 4096;
            1:       return (x == HAS && y == VAS) ? 'hA53 : (x + y) % 4096;
            2:       return int'($urandom_range(0, 4095));
            default: return vis ? 0 : 'hFFF;
        endcase
    endfunction

    task automatic fault();
        if (m_have) n_err_exp++;
        m_have   = 1'b0;
        m_locked = 1'b0;
    endtask

    // One frame of raster; optional short line, misplaced vsync line, reset point, truncation.
    task automatic drive_frame(input int mode, input int short_y, input int bad_v,
                               input int rst_y, input int rst_x, input int n_lines);
        int   len, rgb;
        bit   vis;
        exp_t e;
        for (int y = 0; y < n_lines; y++) begin
            len = (y == short_y) ? HT - 1 : HT;
            for (int x = 0; x < len; x++) begin
                @(negedge clk);
                if (chk_rst) begin
                    check_outputs_zero("midframe_reset");
                    chk_rst = 1'b0;
                end
                rst = 1'b0;
                if (x == 0 && y == 0) begin
                    if (m_have) m_locked = 1'b1;
                    m_have = 1'b1;
                end
                if (x == 0 && (y == bad_v || (short_y >= 0 && y == short_y + 1))) fault();
                if (y == rst_y && x == rst_x) begin
                    rst      = 1'b1;
                    chk_rst  = 1'b1;
                    m_have   = 1'b0;
                    m_locked = 1'b0;
                    // the pixel still in the input register is lost with the reset
                    while (q.size() > 0 && q[$].cyc >= cyc - 1) begin
                        if (q[$].addr == LAST) n_fd_exp--;
                        void'(q.pop_back());
                        n_wr_exp--;
                    end
                end
                vis = (x >= HAS && x < HAS + HA && y >= VAS && y < VAS + VA);
                rgb = colour(mode, x, y, vis);
                bus.h_sync = (x >= HSW);
                bus.v_sync = !(y < 2 || y == bad_v);
                bus.Red    = 4'(rgb >> 8);
                bus.Green  = 4'(rgb >> 4);
                bus.Blue   = 4'(rgb);
                if (m_locked && vis) begin
                    e.cyc  = cyc;
                    e.addr = (y - VAS) * HA + (x - HAS);
                    e.data = rgb;
                    q.push_back(e);
                    n_wr_exp++;
                    if (e.addr == LAST) n_fd_exp++;
                end
            end
        end
        frame_no++;
        check("locked", int'(bus.locked), int'(m_locked));
        check("sync_err_count", n_err_seen, n_err_exp);
        check("write_count", n_wr_seen, n_wr_exp);
        $display("frame %0d mode %0d: locked=%0b writes=%0d sync_err=%0d frame_done=%0d",
                 frame_no, mode, bus.locked, n_wr_seen, n_err_seen, n_fd_seen);
    endtask

    initial begin
        bus.h_sync = 1'b1;
        bus.v_sync = 1'b1;
        bus.Red    = 4'h0;
        bus.Green  = 4'h0;
        bus.Blue   = 4'h0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        drive_frame(0, -1, -1, -1, -1, VT);   // search/align
        drive_frame(0, -1, -1, -1, -1, VT);   // locked, full capture
        drive_frame(1, -1, -1, -1, -1, VT);   // first pixel 0xA53
        drive_frame(2, 10, -1, -1, -1, VT);   // short line
        drive_frame(2, -1, -1, -1, -1, VT);
        drive_frame(2, -1, -1, -1, -1, VT);
        drive_frame(2, -1, 12, -1, -1, VT);   // misplaced vsync
        drive_frame(2, -1, -1, -1, -1, VT);
        drive_frame(2, -1, -1, -1, -1, VT);
        drive_frame(3, -1, -1, -1, -1, VT);   // blanking white, visible black
        drive_frame(2, -1, -1, 8, 16, VT);    // reset mid-frame
        drive_frame(2, -1, -1, -1, -1, VT);
        drive_frame(2, -1, -1, -1, -1, VT);
        drive_frame(0, -1, -1, -1, -1, 1);    // start of next frame, lets writes drain

        check("queue_empty", q.size(), 0);
        check("frame_done_count", n_fd_seen, n_fd_exp);
        check("frame_done_total", n_fd_exp, 6);
        check("sync_err_total", n_err_seen, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the 640x480 VGA output.
- Samples `h_sync`, `v_sync` and the 4-bit `Red`/`Green`/`Blue` lines on the pixel clock and recovers horizontal and vertical position from the sync edges.
- Locks onto the 800x525 raster and writes every visible pixel into a frame buffer through a simple write port.
- Used for loopback self-test of the display path and as a capture front-end for an external VGA source.

## Interface
- `H_TOTAL`, 800: pixel clocks per line.
- `H_SYNC`, 96: `h_sync` low width in clocks.
- `H_ACT_START`, 144: first visible pixel position in a line.
- `H_ACT`, 640: visible pixels per line.
- `V_TOTAL`, 525: lines per frame.
- `V_ACT_START`, 35: first visible line.
- `V_ACT`, 480: visible lines.
- `clk`  in  1  pixel clock, 25 MHz.
- `rst`  in  1  reset, synchronous, active-high.
- `h_sync`  in  1  horizontal sync, active-low.
- `v_sync`  in  1  vertical sync, active-low.
- `Red`, `Green`, `Blue`  in  4 each  colour data.
- `wr_en`  out  1  one-cycle frame-buffer write strobe.
- `wr_addr`  out  19  linear pixel address, 0..307199.
- `wr_data`  out  16  {4'h0, Red, Green, Blue}.
- `locked`  out  1  raster timing verified; capture active.
- `frame_done`  out  1  pulse coincident with the write of address 307199.
- `sync_err`  out  1  one-cycle pulse on any timing violation.

## Operation
- **Input register:** all inputs are registered once (stage S).
- **Edge detection:** runs on stage S against its one-cycle-delayed copy.
  - H-fall = S `h_sync` 1->0.
  - V-fall = S `v_sync` 1->0.
- **Position tracking:**
  - The S sample carrying H-fall has `h_pos` = 0. `h_pos` increments by 1 per clock after that; it is 10 bits wide.
  - On H-fall: if V-fall occurs in the same cycle, `v_pos` = 0; otherwise `v_pos` = previous `v_pos` + 1. `v_pos` is 10 bits wide.
- **Visible window:**
  - Horizontal: `h_pos` in 144..783.
  - Vertical: `v_pos` in 35..514.
  - Address: `wr_addr` = (`v_pos`-35)*640 + (`h_pos`-144).
- **State machine** (states SEARCH, ALIGN, LOCKED):
  - SEARCH:
    - Enters ALIGN on H-fall coincident with V-fall.
    - V-fall without H-fall stays in SEARCH.
  - ALIGN:
    - Checks one full frame.
    - Enters LOCKED on the next coincident H-fall+V-fall with no violation in between.
    - A violation returns to SEARCH.
  - LOCKED:
    - Writes visible pixels.
    - A violation pulses `sync_err`, clears `locked` and returns to SEARCH.
- **Violations** (checked in ALIGN and LOCKED):
  - H-fall when the previous sample's `h_pos` != 799 (short line).
  - `h_pos` = 799 and no H-fall on the next sample (long line).
  - V-fall when the previous line's `v_pos` != 524, or V-fall without a coincident H-fall.
  - H-fall at `v_pos` = 524 without V-fall (long frame).
- **Writes:** only in LOCKED, only inside the visible window. Blanking-interval colour data is ignored.
- **Arithmetic:** address is computed without overflow. 640*479+639 = 307199 fits in 19 bits.

## Timing
- **Reset:** `wr_en`, `wr_addr`, `wr_data`, `locked`, `frame_done` and `sync_err` are all 0; state is SEARCH. Counters are 0.
- **Write latency:**
  - Colour present at the pins in cycle N is written with `wr_en`=1 in cycle N+2: one input register plus one output register.
  - `wr_en` is high for exactly one cycle per pixel, for 640 consecutive cycles per visible line.
- **Address order:** monotonic increasing within a frame with no gaps, then restarts at 0 on the next frame.
- **`locked`:** rises in the cycle after the S-stage coincident H-fall+V-fall that completes ALIGN. The first capture starts at line 35 of that frame.
- **`frame_done`:** asserted in the same cycle as `wr_en` with `wr_addr` = 307199.
- **`sync_err`:** asserted in the cycle after the violating S sample. `locked` falls in that same cycle. No `wr_en` from that cycle on until relock.
- **Reset mid-frame:** outputs return to reset values the cycle after `rst` is sampled high. Relock requires one full clean frame, as from power-up.
- **Simultaneous events:** violation detection takes priority over a pending write in the same cycle; that pixel is not written.

## Test plan
- **Nominal capture:** reset, then drive 3 frames of 800x525 raster timing with colour = (x+y) mod 4096.
  - `locked` rises after frame 1.
  - Frames 2 and 3 each produce exactly 307200 writes, addresses 0..307199 in order, with correct `wr_data`.
  - `frame_done` pulses twice.
- **First pixel latency:** while locked, drive R=4'hA, G=4'h5, B=4'h3 at H=144, V=35 in cycle N.
  - `wr_en`=1, `wr_addr`=0, `wr_data`=16'h0A53 in cycle N+2.
- **Short line:** while locked, drive a 799-clock line at V=200.
  - `sync_err` pulses once, `locked`=0, and no writes follow.
  - Two clean frames later, `locked`=1 again.
- **Misplaced vsync:** while locked, pull `v_sync` low at line 300.
  - `sync_err` pulses once, state returns to SEARCH, and relock occurs after one full frame.
- **Blanking data ignored:** drive RGB=12'hFFF throughout blanking and 12'h000 in the visible window.
  - All `wr_data`=16'h0000.
  - Count of `wr_en` cycles per frame is exactly 307200.
- **Reset mid-frame:** assert `rst` for 1 cycle at V=100, H=400 while locked.
  - All outputs are 0 the next cycle.
  - `locked` stays 0 until one full clean frame has passed.
